pipe_stall_flush_regs: RTL

// Fetch/decode/execute pipeline registers that consume the hazard controls (StallF, StallD, FlushE)
// and the branch redirect (PCSrcD) of the 5-stage MIPS core. Holds PC, IF/ID and ID/EX state,

---
 rtl/pipe_stall_flush_regs_if.sv | 64 ++++++
 rtl/pipe_stall_flush_regs.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_flush_regs_if.sv
// Signal bundle between the hazard/decode logic and the F/D/E pipeline registers.
// The slave modport is the pipeline-register block; the master drives decode and hazard inputs.
interface pipe_stall_flush_regs_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 StallF;
  logic                 StallD;
  logic                 FlushE;
  logic                 PCSrcD;
  logic [31:0]          PCBranchD;
  logic [31:0]          InstrF;
  logic                 RegWriteD;
  logic                 MemtoRegD;
  logic                 MemWriteD;
  logic                 ALUSrcD;
  logic                 RegDstD;
  logic                 BranchD;
  logic [2:0]           ALUControlD;
  logic [31:0]          RD1D;
  logic [31:0]          RD2D;

  logic [31:0]          PCF;
  logic [31:0]          InstrD;
  logic [31:0]          PCPlus4D;
  logic                 ValidD;
  logic [4:0]           RsD;
  logic [4:0]           RtD;
  logic                 RegWriteE;
  logic                 MemtoRegE;
  logic                 MemWriteE;
  logic                 ALUSrcE;
  logic                 RegDstE;
  logic [2:0]           ALUControlE;
  logic [31:0]          RD1E;
  logic [31:0]          RD2E;
  logic [31:0]          SignImmE;
  logic [4:0]           RsE;
  logic [4:0]           RtE;
  logic [4:0]           RdE;
  logic                 ValidE;
  logic [4:0]           WriteRegE;
  logic [CNT_WIDTH-1:0] StallCount;
  logic [CNT_WIDTH-1:0] FlushCount;

  modport master (
    output StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
           RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD,
           ALUControlD, RD1D, RD2D,
    input  PCF, InstrD, PCPlus4D, ValidD, RsD, RtD,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE, WriteRegE,
           StallCount, FlushCount
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
           RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD,
           ALUControlD, RD1D, RD2D,
    output PCF, InstrD, PCPlus4D, ValidD, RsD, RtD,
           RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE, WriteRegE,
           StallCount, FlushCount
  );
endinterface

// File: rtl/pipe_stall_flush_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core, driven by the hazard
// unit's stall/flush controls, plus saturating stall/flush event counters for debug.
module pipe_stall_flush_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_stall_flush_regs_if.slave bus
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sign_imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } ex_t;

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pc_plus4_f;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pcplus4_d_q, pcplus4_d_d;
  logic        valid_d_q, valid_d_d;
  ex_t         ex_q, ex_d;

  logic [CNT_WIDTH-1:0] cnt_q [2];
  logic [CNT_WIDTH-1:0] cnt_d [2];
  logic [1:0]           cnt_evt;

  // BranchD is resolved upstream in decode; nothing here depends on it.
  logic unused_branch_d;
  assign unused_branch_d = bus.BranchD;

  assign pc_plus4_f = pcf_q + 32'd4;

  always_comb begin
    pcf_d = pcf_q;
    if (!bus.StallF) begin
      pcf_d = bus.PCSrcD ? bus.PCBranchD : pc_plus4_f;
    end
  end

  // A stalled IF/ID wins over a redirect: the branch operands are not yet resolved.
  always_comb begin
    instr_d_d   = instr_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;
    if (!bus.StallD) begin
      if (bus.PCSrcD) begin
        instr_d_d   = 32'd0;
        pcplus4_d_d = 32'd0;
        valid_d_d   = 1'b0;
      end else begin
        instr_d_d   = bus.InstrF;
        pcplus4_d_d = pc_plus4_f;
        valid_d_d   = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d = '0;
    if (!bus.FlushE) begin
      ex_d.reg_write  = bus.RegWriteD;
      ex_d.mem_to_reg = bus.MemtoRegD;
      ex_d.mem_write  = bus.MemWriteD;
      ex_d.alu_src    = bus.ALUSrcD;
      ex_d.reg_dst    = bus.RegDstD;
      ex_d.alu_ctrl   = bus.ALUControlD;
      ex_d.rd1        = bus.RD1D;
      ex_d.rd2        = bus.RD2D;
      ex_d.sign_imm   = {{16{instr_d_q[15]}}, instr_d_q[15:0]};
      ex_d.rs         = instr_d_q[25:21];
      ex_d.rt         = instr_d_q[20:16];
      ex_d.rd         = instr_d_q[15:11];
      ex_d.valid      = valid_d_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q       <= RESET_PC;
      instr_d_q   <= 32'd0;
      pcplus4_d_q <= 32'd0;
      valid_d_q   <= 1'b0;
      ex_q        <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instr_d_q   <= instr_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
      ex_q        <= ex_d;
    end
  end

  // Counter 0 counts decode stalls, counter 1 counts E flushes and taken redirects.
  assign cnt_evt[0] = bus.StallD;
  assign cnt_evt[1] = bus.FlushE | (bus.PCSrcD & ~bus.StallD);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_evt[gi] && (cnt_q[gi] != {CNT_WIDTH{1'b1}})) begin
          cnt_d[gi] = cnt_q[gi] + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign bus.PCF         = pcf_q;
  assign bus.InstrD      = instr_d_q;
  assign bus.PCPlus4D    = pcplus4_d_q;
  assign bus.ValidD      = valid_d_q;
  assign bus.RsD         = instr_d_q[25:21];
  assign bus.RtD         = instr_d_q[20:16];
  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.MemtoRegE   = ex_q.mem_to_reg;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.ALUSrcE     = ex_q.alu_src;
  assign bus.RegDstE     = ex_q.reg_dst;
  assign bus.ALUControlE = ex_q.alu_ctrl;
  assign bus.RD1E        = ex_q.rd1;
  assign bus.RD2E        = ex_q.rd2;
  assign bus.SignImmE    = ex_q.sign_imm;
  assign bus.RsE         = ex_q.rs;
  assign bus.RtE         = ex_q.rt;
  assign bus.RdE         = ex_q.rd;
  assign bus.ValidE      = ex_q.valid;
  assign bus.WriteRegE   = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
  assign bus.StallCount  = cnt_q[0];
  assign bus.FlushCount  = cnt_q[1];

endmodule
